// File: rtl/ce_divider.sv
// Free-running clock-enable generator: emits a registered one-cycle strobe on
// CE_OUT once every DIVISOR rising edges of CLK.
module ce_divider #(
    parameter int unsigned DIVISOR = 50000
) (
    input  logic CLK,
    input  logic IN_CLR,
    output logic CE_OUT
);

    localparam int unsigned CNT_W = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    generate
        if (DIVISOR < 1 || DIVISOR > (1 << 24)) begin : g_bad_divisor
            $error("ce_divider: DIVISOR must be in 1..2^24");
        end
    endgenerate

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ce_q;
    logic             ce_d;

    // Any count above LAST (only reachable through an upset) recovers to zero.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        ce_d    = 1'b0;
        if (count_q == LAST) begin
            count_d = '0;
            ce_d    = 1'b1;
        end else if (count_q > LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            count_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ce_q    <= ce_d;
        end
    end

    assign CE_OUT = ce_q;

endmodule

// File: tb/tb_ce_divider.sv
// Directed bench for ce_divider: reset, basic period, mid-period and mid-pulse
// reset, degenerate divisors, and long-period pulse spacing.
module tb_ce_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce4, ce1, ce2, ce1k, ce50k;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ce_divider #(.DIVISOR(4))     u_div4   (.CLK(clk), .IN_CLR(rst_n), .CE_OUT(ce4));
    ce_divider #(.DIVISOR(1))     u_div1   (.CLK(clk), .IN_CLR(rst_n), .CE_OUT(ce1));
    ce_divider #(.DIVISOR(2))     u_div2   (.CLK(clk), .IN_CLR(rst_n), .CE_OUT(ce2));
    ce_divider #(.DIVISOR(1000))  u_div1k  (.CLK(clk), .IN_CLR(rst_n), .CE_OUT(ce1k));
    ce_divider #(.DIVISOR(50000)) u_div50k (.CLK(clk), .IN_CLR(rst_n), .CE_OUT(ce50k));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n1k, first1k, last1k, bad1k, n50k, first50k;

        // Reset held across three edges
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ce4", 32'(ce4), 32'd0);
            check("rst_cnt4", 32'(u_div4.count_q), 32'd0);
            check("rst_ce1", 32'(ce1), 32'd0);
        end

        // Basic operation after release
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("basic_ce4_e%0d", k), 32'(ce4), 32'((k % 4) == 0));
            check($sformatf("deg_ce2_e%0d", k), 32'(ce2), 32'((k % 2) == 0));
            check($sformatf("deg_ce1_e%0d", k), 32'(ce1), 32'd1);
        end

        // Mid-period reset between edges 2 and 3
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midper_ce4", 32'(ce4), 32'd0);
        check("midper_cnt4", 32'(u_div4.count_q), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("midper_rel_e%0d", k), 32'(ce4), 32'(k == 4));
        end

        // Mid-pulse reset: CE_OUT must drop before the next edge
        check("pulse_before", 32'(ce4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midpulse_ce4", 32'(ce4), 32'd0);
        check("midpulse_ce1", 32'(ce1), 32'd0);
        @(negedge clk);

        // Long run: DIVISOR=1000 spacing and first DIVISOR=50000 pulse
        n1k = 0; first1k = 0; last1k = 0; bad1k = 0; n50k = 0; first50k = 0;
        rst_n = 1'b1;
        for (int k = 1; k <= 50001; k++) begin
            step();
            if (ce1k) begin
                if (last1k != 0 && (k - last1k) != 1000) bad1k++;
                if (first1k == 0) first1k = k;
                last1k = k;
                n1k++;
            end
            if (ce50k) begin
                if (first50k == 0) first50k = k;
                n50k++;
            end
        end
        check("d1k_pulses", 32'(n1k), 32'd50);
        check("d1k_first", 32'(first1k), 32'd1000);
        check("d1k_last", 32'(last1k), 32'd50000);
        check("d1k_bad_gaps", 32'(bad1k), 32'd0);
        check("d50k_pulses", 32'(n50k), 32'd1);
        check("d50k_first", 32'(first50k), 32'd50000);
        check("d50k_low_after", 32'(ce50k), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
